// File: rtl/worksheet_decoder.sv
// -----------------------------------------------------------------------------
// worksheet_decoder
//
// Byte-stream parser for the column-organised arithmetic worksheet. Raw ASCII
// bytes are turned into numbered argument events (row, column, value) and
// operator events (column, '+' or '*'). The number of argument rows is learned
// from the input: the first line whose first non-space byte is an operator is
// taken as the operator row.
//
// Optional feature macro: DIGIT_STREAM_EN
//   When defined, a per-digit event stream (row, character offset, value) is
//   produced for column-wise number assembly downstream.
//
// Ports:
//   clk              in   sole clock
//   rst              in   synchronous active-high reset
//   byte_valid       in   qualifies byte_data
//   byte_data        in   ASCII input byte
//   arg_valid        out  one-cycle pulse, an argument completed
//   arg_row          out  0-based row of the argument
//   arg_col          out  0-based problem column of the argument
//   arg_data         out  decimal value of the argument (modulo 2**DATA_WIDTH)
//   arg_overflow     out  value did not fit in DATA_WIDTH (with arg_valid)
//   operand_valid    out  one-cycle pulse, an operator was decoded
//   operand_col      out  column of the operator
//   operand_mult_add out  1 = '*', 0 = '+'
//   done             out  one-cycle pulse after the LF ending the operator row
//   arg_rows         out  number of argument rows, valid from done onward
//   format_error     out  sticky malformed-input flag, cleared only by rst
//   digit_valid      out  (DIGIT_STREAM_EN) one pulse per digit in an argument row
//   digit_row        out  (DIGIT_STREAM_EN) row of the digit
//   digit_char_col   out  (DIGIT_STREAM_EN) byte offset of the digit in its line
//   digit_value      out  (DIGIT_STREAM_EN) value of the digit
// -----------------------------------------------------------------------------
module worksheet_decoder #(
    parameter int ROW_WIDTH      = 3,
    parameter int COL_WIDTH      = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int CHAR_COL_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      arg_valid,
    output logic [ROW_WIDTH-1:0]      arg_row,
    output logic [COL_WIDTH-1:0]      arg_col,
    output logic [DATA_WIDTH-1:0]     arg_data,
    output logic                      arg_overflow,
    output logic                      operand_valid,
    output logic [COL_WIDTH-1:0]      operand_col,
    output logic                      operand_mult_add,
    output logic                      done,
    output logic [ROW_WIDTH-1:0]      arg_rows,
    output logic                      format_error
`ifdef DIGIT_STREAM_EN
    ,
    output logic                      digit_valid,
    output logic [ROW_WIDTH-1:0]      digit_row,
    output logic [CHAR_COL_WIDTH-1:0] digit_char_col,
    output logic [3:0]                digit_value
`endif
);

    typedef enum logic [1:0] {
        ARGS,
        OPS,
        DONE
    } state_t;

    // Reaching this row index before the operator row means too many rows.
    localparam logic [ROW_WIDTH-1:0] ROW_MAX  = '1;
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_MAX - 1'b1;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic                  acc_ovf, acc_ovf_nxt;
    logic                  in_token, in_token_nxt;
    logic                  line_started, line_started_nxt;
    logic [ROW_WIDTH-1:0]  row, row_nxt;
    logic [COL_WIDTH-1:0]  col, col_nxt;

    logic                  arg_valid_nxt;
    logic [ROW_WIDTH-1:0]  arg_row_nxt;
    logic [COL_WIDTH-1:0]  arg_col_nxt;
    logic [DATA_WIDTH-1:0] arg_data_nxt;
    logic                  arg_overflow_nxt;
    logic                  operand_valid_nxt;
    logic [COL_WIDTH-1:0]  operand_col_nxt;
    logic                  operand_mult_add_nxt;
    logic                  done_nxt;
    logic [ROW_WIDTH-1:0]  arg_rows_nxt;
    logic                  format_error_nxt;

`ifdef DIGIT_STREAM_EN
    logic [CHAR_COL_WIDTH-1:0] char_col, char_col_nxt;
    logic                      digit_valid_nxt;
    logic [ROW_WIDTH-1:0]      digit_row_nxt;
    logic [CHAR_COL_WIDTH-1:0] digit_char_col_nxt;
    logic [3:0]                digit_value_nxt;
`else
    // CHAR_COL_WIDTH only sizes the digit-stream counter, which is not built
    // in this configuration; the check merely keeps the parameter referenced.
    if (CHAR_COL_WIDTH < 1) begin : g_char_col_width_check
    end
`endif

    // Byte classification
    logic       is_digit, is_space, is_lf, is_cr, is_plus, is_star, is_op;
    logic [3:0] digit;

    assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
    assign is_space = (byte_data == 8'h20);
    assign is_lf    = (byte_data == 8'h0A);
    assign is_cr    = (byte_data == 8'h0D);
    assign is_plus  = (byte_data == 8'h2B);
    assign is_star  = (byte_data == 8'h2A);
    assign is_op    = is_plus | is_star;
    assign digit    = byte_data[3:0];

    // acc*10 + digit computed four bits wider so a wrap is visible in the top bits.
    logic [DATA_WIDTH+3:0] acc_wide, acc_step;

    always_comb begin
        acc_wide = (DATA_WIDTH+4)'(acc);
        acc_step = (acc_wide << 3) + (acc_wide << 1) + (DATA_WIDTH+4)'(digit);
    end

    // State register for the ARGS -> OPS -> DONE sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARGS;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decode. A CR or an unqualified byte leaves
    // everything untouched, which is what makes gaps and CRLF transparent.
    always_comb begin
        state_nxt            = state;
        acc_nxt              = acc;
        acc_ovf_nxt          = acc_ovf;
        in_token_nxt         = in_token;
        line_started_nxt     = line_started;
        row_nxt              = row;
        col_nxt              = col;
        arg_valid_nxt        = 1'b0;
        arg_row_nxt          = arg_row;
        arg_col_nxt          = arg_col;
        arg_data_nxt         = arg_data;
        arg_overflow_nxt     = arg_overflow;
        operand_valid_nxt    = 1'b0;
        operand_col_nxt      = operand_col;
        operand_mult_add_nxt = operand_mult_add;
        done_nxt             = 1'b0;
        arg_rows_nxt         = arg_rows;
        format_error_nxt     = format_error;
`ifdef DIGIT_STREAM_EN
        char_col_nxt         = char_col;
        digit_valid_nxt      = 1'b0;
        digit_row_nxt        = digit_row;
        digit_char_col_nxt   = digit_char_col;
        digit_value_nxt      = digit_value;
`endif

        if (byte_valid && !is_cr) begin
`ifdef DIGIT_STREAM_EN
            char_col_nxt = is_lf ? '0 : char_col + 1'b1;
`endif
            case (state)
                ARGS: begin
                    if (is_digit) begin
                        line_started_nxt = 1'b1;
                        in_token_nxt     = 1'b1;
                        if (in_token) begin
                            acc_nxt     = acc_step[DATA_WIDTH-1:0];
                            acc_ovf_nxt = acc_ovf | (|acc_step[DATA_WIDTH+3:DATA_WIDTH]);
                        end else begin
                            acc_nxt     = DATA_WIDTH'(digit);
                            acc_ovf_nxt = 1'b0;
                        end
`ifdef DIGIT_STREAM_EN
                        digit_valid_nxt    = 1'b1;
                        digit_row_nxt      = row;
                        digit_char_col_nxt = char_col;
                        digit_value_nxt    = digit;
`endif
                    end else if (is_space || is_lf) begin
                        // Report with the pre-update row/column, then advance.
                        if (in_token) begin
                            if (!format_error) begin
                                arg_valid_nxt    = 1'b1;
                                arg_row_nxt      = row;
                                arg_col_nxt      = col;
                                arg_data_nxt     = acc;
                                arg_overflow_nxt = acc_ovf;
                            end
                            col_nxt      = col + 1'b1;
                            in_token_nxt = 1'b0;
                        end
                        if (is_lf) begin
                            col_nxt          = '0;
                            line_started_nxt = 1'b0;
                            // A line without any token is not counted as a row.
                            if (line_started) begin
                                if (row >= ROW_LAST) begin
                                    format_error_nxt = 1'b1;
                                end
                                if (row != ROW_MAX) begin
                                    row_nxt = row + 1'b1;
                                end
                            end
                        end
                    end else if (is_op) begin
                        line_started_nxt = 1'b1;
                        if (!line_started) begin
                            // Operator row discovered: this byte is its first operator.
                            arg_rows_nxt = row;
                            state_nxt    = OPS;
                            if (!format_error) begin
                                operand_valid_nxt    = 1'b1;
                                operand_col_nxt      = col;
                                operand_mult_add_nxt = is_star;
                            end
                            col_nxt = col + 1'b1;
                        end else begin
                            format_error_nxt = 1'b1;
                        end
                    end else begin
                        line_started_nxt = 1'b1;
                        format_error_nxt = 1'b1;
                    end
                end

                OPS: begin
                    if (is_op) begin
                        if (!format_error) begin
                            operand_valid_nxt    = 1'b1;
                            operand_col_nxt      = col;
                            operand_mult_add_nxt = is_star;
                        end
                        col_nxt = col + 1'b1;
                    end else if (is_lf) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (!is_space) begin
                        format_error_nxt = 1'b1;
                    end
                end

                DONE: begin
                end

                default: begin
                    state_nxt = ARGS;
                end
            endcase
        end
    end

    // Parser context and registered outputs. Reset discards any partial token.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc              <= '0;
            acc_ovf          <= 1'b0;
            in_token         <= 1'b0;
            line_started     <= 1'b0;
            row              <= '0;
            col              <= '0;
            arg_valid        <= 1'b0;
            arg_row          <= '0;
            arg_col          <= '0;
            arg_data         <= '0;
            arg_overflow     <= 1'b0;
            operand_valid    <= 1'b0;
            operand_col      <= '0;
            operand_mult_add <= 1'b0;
            done             <= 1'b0;
            arg_rows         <= '0;
            format_error     <= 1'b0;
        end else begin
            acc              <= acc_nxt;
            acc_ovf          <= acc_ovf_nxt;
            in_token         <= in_token_nxt;
            line_started     <= line_started_nxt;
            row              <= row_nxt;
            col              <= col_nxt;
            arg_valid        <= arg_valid_nxt;
            arg_row          <= arg_row_nxt;
            arg_col          <= arg_col_nxt;
            arg_data         <= arg_data_nxt;
            arg_overflow     <= arg_overflow_nxt;
            operand_valid    <= operand_valid_nxt;
            operand_col      <= operand_col_nxt;
            operand_mult_add <= operand_mult_add_nxt;
            done             <= done_nxt;
            arg_rows         <= arg_rows_nxt;
            format_error     <= format_error_nxt;
        end
    end

`ifdef DIGIT_STREAM_EN
    // Digit stream registers and the character-offset counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_col       <= '0;
            digit_valid    <= 1'b0;
            digit_row      <= '0;
            digit_char_col <= '0;
            digit_value    <= '0;
        end else begin
            char_col       <= char_col_nxt;
            digit_valid    <= digit_valid_nxt;
            digit_row      <= digit_row_nxt;
            digit_char_col <= digit_char_col_nxt;
            digit_value    <= digit_value_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_worksheet_decoder.sv
// -----------------------------------------------------------------------------
// tb_worksheet_decoder
//
// Self-checking bench for worksheet_decoder. A default-width instance runs a
// table of whole-worksheet scenarios; a DATA_WIDTH=8 instance shares the same
// input stream and is observed only for the overflow sequence. Digit-stream
// checks are compiled in with DIGIT_STREAM_EN.
// -----------------------------------------------------------------------------
module tb_worksheet_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;

    logic        arg_valid, arg_overflow, operand_valid, operand_mult_add, done, format_error;
    logic [2:0]  arg_row, arg_rows;
    logic [9:0]  arg_col, operand_col;
    logic [15:0] arg_data;

    logic        s_arg_valid, s_arg_overflow, s_operand_valid, s_operand_mult_add, s_done, s_format_error;
    logic [2:0]  s_arg_row, s_arg_rows;
    logic [9:0]  s_arg_col, s_operand_col;
    logic [7:0]  s_arg_data;

`ifdef DIGIT_STREAM_EN
    logic        digit_valid, s_digit_valid;
    logic [2:0]  digit_row, s_digit_row;
    logic [11:0] digit_char_col, s_digit_char_col;
    logic [3:0]  digit_value, s_digit_value;
`endif

    worksheet_decoder dut (
        .clk              (clk),
        .rst              (rst),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .arg_valid        (arg_valid),
        .arg_row          (arg_row),
        .arg_col          (arg_col),
        .arg_data         (arg_data),
        .arg_overflow     (arg_overflow),
        .operand_valid    (operand_valid),
        .operand_col      (operand_col),
        .operand_mult_add (operand_mult_add),
        .done             (done),
        .arg_rows         (arg_rows),
        .format_error     (format_error)
`ifdef DIGIT_STREAM_EN
        ,
        .digit_valid      (digit_valid),
        .digit_row        (digit_row),
        .digit_char_col   (digit_char_col),
        .digit_value      (digit_value)
`endif
    );

    worksheet_decoder #(.DATA_WIDTH(8)) dut_small (
        .clk              (clk),
        .rst              (rst),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .arg_valid        (s_arg_valid),
        .arg_row          (s_arg_row),
        .arg_col          (s_arg_col),
        .arg_data         (s_arg_data),
        .arg_overflow     (s_arg_overflow),
        .operand_valid    (s_operand_valid),
        .operand_col      (s_operand_col),
        .operand_mult_add (s_operand_mult_add),
        .done             (s_done),
        .arg_rows         (s_arg_rows),
        .format_error     (s_format_error)
`ifdef DIGIT_STREAM_EN
        ,
        .digit_valid      (s_digit_valid),
        .digit_row        (s_digit_row),
        .digit_char_col   (s_digit_char_col),
        .digit_value      (s_digit_value)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  row;
        logic [9:0]  col;
        logic [15:0] data;
        logic        ovf;
    } arg_ev_t;

    typedef struct packed {
        logic [9:0] col;
        logic       mult;
    } op_ev_t;

    typedef struct {
        string name;
        string stream;
        bit    gaps;
        bit    cr;
        int    exp_set;
        int    n_args;
        int    n_ops;
        int    rows;
        bit    err;
    } scen_t;

    arg_ev_t arg_q[$];
    op_ev_t  op_q[$];
    arg_ev_t s_arg_q[$];
    int      done_cnt = 0;

    int errors = 0;
    int checks = 0;

    // Event recorders, sampled on the falling edge so each pulse is seen once.
    always @(negedge clk) begin
        if (arg_valid) arg_q.push_back('{arg_row, arg_col, arg_data, arg_overflow});
        if (operand_valid) op_q.push_back('{operand_col, operand_mult_add});
        if (done) done_cnt++;
        if (s_arg_valid) s_arg_q.push_back('{s_arg_row, s_arg_col, {8'h00, s_arg_data}, s_arg_overflow});
    end

`ifdef DIGIT_STREAM_EN
    typedef struct packed {
        logic [2:0]  row;
        logic [11:0] ccol;
        logic [3:0]  val;
    } dig_ev_t;
    dig_ev_t dig_q[$];
    always @(negedge clk) begin
        if (digit_valid) dig_q.push_back('{digit_row, digit_char_col, digit_value});
    end
`endif

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Drives a string; optional idle gaps (with junk on byte_data) and CR before LF.
    task automatic applyStimulus(input string s, input bit gaps, input bit cr);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    byte_valid = 1'b0;
                    byte_data  = 8'h78;
                    @(negedge clk);
                end
            end
            if (cr && s[i] == 8'h0A) sendByte(8'h0D);
            sendByte(s[i]);
        end
        byte_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".arg_valid"},        arg_valid,        0);
        checkOutput({tag, ".arg_row"},          arg_row,          0);
        checkOutput({tag, ".arg_col"},          arg_col,          0);
        checkOutput({tag, ".arg_data"},         arg_data,         0);
        checkOutput({tag, ".arg_overflow"},     arg_overflow,     0);
        checkOutput({tag, ".operand_valid"},    operand_valid,    0);
        checkOutput({tag, ".operand_col"},      operand_col,      0);
        checkOutput({tag, ".operand_mult_add"}, operand_mult_add, 0);
        checkOutput({tag, ".done"},             done,             0);
        checkOutput({tag, ".arg_rows"},         arg_rows,         0);
        checkOutput({tag, ".format_error"},     format_error,     0);
    endtask

    localparam string EXAMPLE = "123 328  51 64 \n 45 64  387 23 \n  6 98  215 314\n*   +   *   +  \n";

    arg_ev_t exp_args [2][12];
    op_ev_t  exp_ops  [2][4];
    scen_t   scen     [5];

    // Runs one full worksheet and compares events against an expected set.
    task automatic runAndCompare(input string name, input string stream, input bit gaps, input bit cr,
                                 input int set, input int n_args, input int n_ops, input int rows,
                                 input bit err);
        int ba, bo, bd;
        ba = arg_q.size();
        bo = op_q.size();
        bd = done_cnt;
        applyStimulus(stream, gaps, cr);
        repeat (4) @(negedge clk);
        checkOutput({name, ".arg_count"}, arg_q.size() - ba, n_args);
        for (int i = 0; i < n_args; i++) begin
            if (ba + i < arg_q.size())
                checkOutput($sformatf("%s.arg%0d", name, i), arg_q[ba + i], exp_args[set][i]);
        end
        checkOutput({name, ".op_count"}, op_q.size() - bo, n_ops);
        for (int i = 0; i < n_ops; i++) begin
            if (bo + i < op_q.size())
                checkOutput($sformatf("%s.op%0d", name, i), op_q[bo + i], exp_ops[set][i]);
        end
        checkOutput({name, ".done_count"},   done_cnt - bd, 1);
        checkOutput({name, ".arg_rows"},     arg_rows,      rows);
        checkOutput({name, ".format_error"}, format_error,  err);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ba, sa;

        exp_args[0] = '{'{3'd0, 10'd0, 16'd123, 1'b0}, '{3'd0, 10'd1, 16'd328, 1'b0},
                        '{3'd0, 10'd2, 16'd51,  1'b0}, '{3'd0, 10'd3, 16'd64,  1'b0},
                        '{3'd1, 10'd0, 16'd45,  1'b0}, '{3'd1, 10'd1, 16'd64,  1'b0},
                        '{3'd1, 10'd2, 16'd387, 1'b0}, '{3'd1, 10'd3, 16'd23,  1'b0},
                        '{3'd2, 10'd0, 16'd6,   1'b0}, '{3'd2, 10'd1, 16'd98,  1'b0},
                        '{3'd2, 10'd2, 16'd215, 1'b0}, '{3'd2, 10'd3, 16'd314, 1'b0}};
        exp_ops[0]  = '{'{10'd0, 1'b1}, '{10'd1, 1'b0}, '{10'd2, 1'b1}, '{10'd3, 1'b0}};
        exp_args[1] = '{'{3'd0, 10'd0, 16'd1,  1'b0}, '{3'd0, 10'd1, 16'd2,  1'b0},
                        '{3'd1, 10'd0, 16'd3,  1'b0}, '{3'd1, 10'd1, 16'd4,  1'b0},
                        '{3'd2, 10'd0, 16'd5,  1'b0}, '{3'd2, 10'd1, 16'd6,  1'b0},
                        '{3'd3, 10'd0, 16'd7,  1'b0}, '{3'd3, 10'd1, 16'd8,  1'b0},
                        '{3'd4, 10'd0, 16'd9,  1'b0}, '{3'd4, 10'd1, 16'd10, 1'b0},
                        '{3'd0, 10'd0, 16'd0,  1'b0}, '{3'd0, 10'd0, 16'd0,  1'b0}};
        exp_ops[1]  = '{'{10'd0, 1'b0}, '{10'd1, 1'b1}, '{10'd0, 1'b0}, '{10'd0, 1'b0}};

        scen[0] = '{"example",   EXAMPLE, 1'b0, 1'b0, 0, 12, 4, 3, 1'b0};
        scen[1] = '{"gaps_cr",   EXAMPLE, 1'b1, 1'b1, 0, 12, 4, 3, 1'b0};
        scen[2] = '{"five_rows", "1 2\n\n3 4\n5 6\n7 8\n9 10\n+ *\n", 1'b0, 1'b0, 1, 10, 2, 5, 1'b0};
        scen[3] = '{"mid_op",    "1 +\n+\n", 1'b0, 1'b0, 1, 1, 0, 1, 1'b1};
        scen[4] = '{"bad_char",  "123 328  51 64 \n 45 x4  387 23 \n  6 98  215 314\n*   +   *   +  \n",
                    1'b0, 1'b0, 0, 5, 0, 3, 1'b1};

        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkResetValues("reset0");

        for (int k = 0; k < 5; k++) begin
            doReset();
            runAndCompare(scen[k].name, scen[k].stream, scen[k].gaps, scen[k].cr, scen[k].exp_set,
                          scen[k].n_args, scen[k].n_ops, scen[k].rows, scen[k].err);
        end

        // Reset after an errored run must restore every output.
        doReset();
        checkResetValues("reset1");

        // Latency: argument pulse one cycle after its terminator, lasting one cycle.
        doReset();
        applyStimulus("5", 1'b0, 1'b0);
        sendByte(8'h20);
        checkOutput("latency.arg_valid", arg_valid, 1);
        checkOutput("latency.arg_data",  arg_data,  5);
        @(negedge clk);
        checkOutput("latency.pulse_end", arg_valid, 0);

        // Mid-stream reset drops the partial token and a byte presented with rst.
        doReset();
        ba = arg_q.size();
        applyStimulus("12", 1'b0, 1'b0);
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h39;
        @(negedge clk);
        rst        = 1'b0;
        byte_valid = 1'b0;
        checkOutput("rst_mid.no_arg", arg_q.size() - ba, 0);
        runAndCompare("rst_mid.resend", EXAMPLE, 1'b0, 1'b0, 0, 12, 4, 3, 1'b0);

        // Overflow on the narrow instance, plain value on the wide one.
        doReset();
        ba = arg_q.size();
        sa = s_arg_q.size();
        applyStimulus("300 7\n+ *\n", 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("ovf.small_count", s_arg_q.size() - sa, 2);
        if (sa + 1 < s_arg_q.size()) begin
            checkOutput("ovf.small_arg0", s_arg_q[sa],     arg_ev_t'({3'd0, 10'd0, 16'd44, 1'b1}));
            checkOutput("ovf.small_arg1", s_arg_q[sa + 1], arg_ev_t'({3'd0, 10'd1, 16'd7,  1'b0}));
        end
        checkOutput("ovf.small_rows", s_arg_rows, 1);
        checkOutput("ovf.small_err",  s_format_error, 0);
        checkOutput("ovf.wide_count", arg_q.size() - ba, 2);
        if (ba < arg_q.size())
            checkOutput("ovf.wide_arg0", arg_q[ba], arg_ev_t'({3'd0, 10'd0, 16'd300, 1'b0}));

`ifdef DIGIT_STREAM_EN
        begin
            int bdig;
            doReset();
            bdig = dig_q.size();
            applyStimulus("  7\n+\n", 1'b0, 1'b0);
            repeat (4) @(negedge clk);
            checkOutput("digit.count", dig_q.size() - bdig, 1);
            if (bdig < dig_q.size())
                checkOutput("digit.event", dig_q[bdig], dig_ev_t'({3'd0, 12'd2, 4'd7}));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
